adc_capture_ctrl: RTL and testbench

Frame-capture sequencer between the ADC front-end (16-bit signed Q1.15 samples with a one-cycle valid strobe) and a single-port sample buffer RAM.
- On a start command it arms, optionally waits for a rising-edge level trigger, then writes a fixed-length, optionally decimated frame into the buffer.
- It signals completion to downstream processing (FFT/display) with a one-cycle done pulse.
- It owns the buffer write port exclusively while busy.

---
 rtl/adc_capture_ctrl.sv | 128 ++++++++++++
 tb/tb_adc_capture_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: arms on start, optionally waits for a rising level trigger, then streams a
// decimated fixed-length frame of ADC samples into the sample buffer and pulses done.
module adc_capture_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   frame_len,
  input  logic [3:0]        decim,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic              err_len
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, DONE} state_t;
  state_t                    state_q;
  logic [ADDR_W:0]           flen_q, wcnt_q;
  logic [3:0]                decim_q, dcnt_q;
  logic                      trig_en_q, prev_valid_q;
  logic signed [DATA_W-1:0]  level_q, prev_q;
  logic [31:0]               tcnt_q;
  logic                      buf_we_q, busy_q, done_q, timed_out_q, err_len_q;
  logic [ADDR_W-1:0]         buf_addr_q;
  logic [DATA_W-1:0]         buf_wdata_q;
  logic                      len_ok, last, trig_hit, tmo, wr;
  assign len_ok   = frame_len != '0 && frame_len <= (ADDR_W+1)'(1 << ADDR_W);
  assign last     = wcnt_q == flen_q - 1'b1;
  assign trig_hit = s_valid && prev_valid_q && prev_q < level_q && $signed(s_data) >= level_q;
  assign tmo      = TIMEOUT_CYC != 0 && tcnt_q == 32'(TIMEOUT_CYC - 1);
  // A sample is stored either as the trigger sample or as a decimation-selected capture sample
  assign wr = state_q == CAPTURE ? s_valid && dcnt_q == '0 : state_q == WAIT_TRIG && trig_hit;
  assign buf_we    = buf_we_q;
  assign buf_addr  = buf_addr_q;
  assign buf_wdata = buf_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign err_len   = err_len_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flen_q       <= '0;
      wcnt_q       <= '0;
      decim_q      <= '0;
      dcnt_q       <= '0;
      trig_en_q    <= 1'b0;
      prev_valid_q <= 1'b0;
      level_q      <= '0;
      prev_q       <= '0;
      tcnt_q       <= '0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      buf_we_q <= wr && !abort;
      done_q   <= 1'b0;
      if (wr && !abort) begin
        buf_addr_q  <= wcnt_q[ADDR_W-1:0];
        buf_wdata_q <= s_data;
        wcnt_q      <= wcnt_q + 1'b1;
      end
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start && !abort) begin
            if (len_ok) begin
              state_q     <= ARM;
              busy_q      <= 1'b1;
              flen_q      <= frame_len;
              decim_q     <= decim;
              trig_en_q   <= trig_en;
              level_q     <= trig_level;
              timed_out_q <= 1'b0;
              err_len_q   <= 1'b0;
            end else err_len_q <= 1'b1;
          end
          ARM: begin
            wcnt_q       <= '0;
            dcnt_q       <= '0;
            tcnt_q       <= '0;
            prev_valid_q <= 1'b0;
            state_q      <= trig_en_q ? WAIT_TRIG : CAPTURE;
          end
          WAIT_TRIG: begin
            tcnt_q <= tcnt_q + 1'b1;
            if (trig_hit) begin
              dcnt_q  <= 4'(decim_q != 4'd0);
              state_q <= last ? DONE : CAPTURE;
            end else if (tmo) begin
              timed_out_q <= 1'b1;
              state_q     <= CAPTURE;
            end else if (s_valid) begin
              prev_q       <= s_data;
              prev_valid_q <= 1'b1;
            end
          end
          CAPTURE: if (s_valid) begin
            dcnt_q <= dcnt_q == decim_q ? 4'd0 : dcnt_q + 1'b1;
            if (dcnt_q == '0 && last) state_q <= DONE;
          end
          DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: stream-level model of which samples land where and when, checked every cycle.
module tb_adc_capture_ctrl;
  localparam int TMO = 100;
  logic clk = 1'b0, rst_n, start, abort, trig_en, s_valid;
  logic [4:0] frame_len;
  logic [3:0] decim;
  logic [15:0] trig_level, s_data;
  logic buf_we, busy, done, timed_out, err_len;
  logic [3:0] buf_addr;
  logic [15:0] buf_wdata;
  adc_capture_ctrl #(.ADDR_W(4), .DATA_W(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_len(frame_len),
    .decim(decim), .trig_en(trig_en), .trig_level(trig_level), .s_data(s_data),
    .s_valid(s_valid), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .busy(busy), .done(done), .timed_out(timed_out), .err_len(err_len));
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] a; logic [15:0] d; int c; bit last;} wr_t;
  wr_t q[$];
  int cnt = 0, total = 0, bad = 0;
  int mode = 0, flen, dec, vk, nst, wcyc, done_cyc = -1;
  int nwr, ndone, first_wc, t0;
  logic [15:0] first_wd, last_wd;
  logic [3:0] first_wa;
  bit pv, exp_busy = 0, exp_to;
  logic signed [15:0] prv, lvl;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", n, act, exp, cnt);
    end
  endtask
  // Trigger search on the raw stream, then keep every (dec+1)-th valid sample up to flen
  task automatic model(input logic v, input logic [15:0] d);
    bit skip = 0;
    if (mode == 1) begin
      if (v && pv && prv < lvl && $signed(d) >= lvl) mode = 2;
      else begin
        if (v) begin prv = d; pv = 1; end
        wcyc++;
        skip = 1;
        if (wcyc == TMO) begin mode = 2; exp_to = 1; end
      end
    end
    if (mode == 2 && !skip && v) begin
      if (vk % (dec + 1) == 0) begin
        q.push_back(wr_t'{4'(nst), d, cnt + 1, nst == flen - 1});
        nst++;
        if (nst == flen) mode = 0;
      end
      vk++;
    end
  endtask
  task automatic compare();
    wr_t e;
    if (cnt == done_cyc) exp_busy = 0;
    if (buf_we) begin
      if (nwr == 0) begin first_wd = buf_wdata; first_wa = buf_addr; first_wc = cnt; end
      last_wd = buf_wdata;
      nwr++;
      if (q.size() == 0) chk("spurious_we", 1, 0);
      else begin
        e = q.pop_front();
        chk("addr", 32'(buf_addr), 32'(e.a));
        chk("data", 32'(buf_wdata), 32'(e.d));
        chk("we_cycle", cnt, e.c);
        if (e.last) done_cyc = cnt + 1;
      end
    end
    if (done) ndone++;
    chk("done", 32'(done), 32'(cnt == done_cyc));
    chk("busy", 32'(busy), 32'(exp_busy));
  endtask
  task automatic step(input logic v, input logic [15:0] d, input logic st, input logic ab);
    s_valid = v; s_data = d; start = st; abort = ab;
    model(v, d);
    @(posedge clk);
    cnt++;
    @(negedge clk);
    compare();
  endtask
  task automatic start_cap(input int fl, input int dc, input bit te, input logic [15:0] lv);
    frame_len = 5'(fl); decim = 4'(dc); trig_en = te; trig_level = lv;
    flen = fl; dec = dc; lvl = lv; nst = 0; vk = 0; pv = 0; wcyc = 0; exp_to = 0;
    done_cyc = -1; nwr = 0; ndone = 0; t0 = cnt;
    exp_busy = 1;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    mode = te ? 1 : 2;
  endtask
  initial begin
    rst_n = 0; start = 0; abort = 0; trig_en = 0; s_valid = 0;
    frame_len = 0; decim = 0; trig_level = 0; s_data = 0;
    nwr = 0; ndone = 0;
    step(0, 0, 0, 0);
    step(1, 16'h1234, 1, 0);
    chk("rst_we", 32'(buf_we), 0);
    chk("rst_addr", 32'(buf_addr), 0);
    chk("rst_wdata", 32'(buf_wdata), 0);
    chk("rst_to", 32'(timed_out), 0);
    chk("rst_err", 32'(err_len), 0);
    rst_n = 1;
    step(0, 0, 0, 0);
    // free-run ramp
    start_cap(8, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 16'(i), 0, 0);
    step(0, 0, 0, 0);
    chk("t1_pending", q.size(), 0);
    chk("t1_nwr", nwr, 8);
    chk("t1_last", 32'(last_wd), 7);
    chk("t1_ndone", ndone, 1);
    // sine trigger at level 0
    start_cap(16, 0, 1, 16'h0000);
    for (int i = 10; i < 60; i++)
      step(1, 16'(int'(8192.0 * $sin(2.0 * 3.141592653589793 * i / 40.0))), 0, 0);
    step(0, 0, 0, 0);
    chk("t2_pending", q.size(), 0);
    chk("t2_first", 32'(first_wd), 0);
    chk("t2_first_cyc", first_wc - t0, 2 + 31);
    chk("t2_nwr", nwr, 16);
    chk("t2_to", 32'(timed_out), 0);
    chk("t2_ndone", ndone, 1);
    // unreachable level: auto-trigger
    start_cap(16, 0, 1, 16'h7FFF);
    for (int i = 0; i < TMO + 18; i++) step(1, 16'h1000, 0, 0);
    chk("t3_pending", q.size(), 0);
    chk("t3_first_cyc", first_wc - t0, 103);
    chk("t3_nwr", nwr, 16);
    chk("t3_to", 32'(timed_out), 32'(exp_to));
    chk("t3_to_lit", 32'(timed_out), 1);
    chk("t3_ndone", ndone, 1);
    // decimation by 4, valid every other cycle
    start_cap(4, 3, 0, 0);
    for (int i = 0; i <= 20; i++) begin step(1, 16'(i), 0, 0); step(0, 0, 0, 0); end
    chk("t4_pending", q.size(), 0);
    chk("t4_nwr", nwr, 4);
    chk("t4_last", 32'(last_wd), 12);
    chk("t4_ndone", ndone, 1);
    chk("t4_to_clr", 32'(timed_out), 0);
    // abort after three writes, then an illegal start
    start_cap(8, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 16'(50 + i), 0, 0);
    mode = 0; q.delete(); exp_busy = 0;
    step(1, 16'h0055, 0, 1);
    step(1, 16'h0056, 0, 0);
    frame_len = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 16'(i), 0, 0);
    chk("t5_nwr", nwr, 3);
    chk("t5_ndone", ndone, 0);
    chk("t5_err", 32'(err_len), 1);
    chk("t5_busy", 32'(busy), 0);
    // reset mid-capture at address 5, then a clean frame
    start_cap(8, 0, 0, 0);
    chk("t6_err_clr", 32'(err_len), 0);
    for (int i = 0; i < 6; i++) step(1, 16'(100 + i), 0, 0);
    chk("t6_addr5", 32'(buf_addr), 5);
    mode = 0; q.delete(); exp_busy = 0; rst_n = 0;
    step(1, 16'h0099, 0, 0);
    chk("t6_rst_we", 32'(buf_we), 0);
    chk("t6_rst_addr", 32'(buf_addr), 0);
    chk("t6_rst_wdata", 32'(buf_wdata), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    rst_n = 1;
    start_cap(4, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 16'(200 + i), 0, 0);
    chk("t6_pending", q.size(), 0);
    chk("t6_first_addr", 32'(first_wa), 0);
    chk("t6_first_data", 32'(first_wd), 200);
    chk("t6_nwr", nwr, 4);
    chk("t6_ndone", ndone, 1);
    // frame_len one past the buffer size is rejected
    frame_len = 5'd17;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("len17_err", 32'(err_len), 1);
    chk("len17_busy", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
